// File: rtl/sram_arbiter.sv
// Arbiter for the shared external SRAM port: VGA has fixed priority, UART and M1 share
// round-robin, a starvation counter forces a UART/M1 grant, and read tags are pipelined.
module sram_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_WAIT     = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        VGA_req,
    input  logic [17:0] VGA_address,
    output logic        VGA_gnt,
    output logic        VGA_read_valid,
    input  logic        UART_req,
    input  logic [17:0] UART_address,
    input  logic [15:0] UART_write_data,
    output logic        UART_gnt,
    input  logic        M1_req,
    input  logic        M1_we_n,
    input  logic [17:0] M1_address,
    input  logic [15:0] M1_write_data,
    output logic        M1_gnt,
    output logic        M1_read_valid,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam int CW = $clog2(MAX_WAIT) + 1;

    logic [CW-1:0] starve_q, starve_d;
    logic          rr_q, rr_d;
    logic [1:0]    tag_q [READ_LATENCY];
    logic [1:0]    tag_d;
    logic          low_pend;
    logic          pick_m1;
    logic          forced;

    assign low_pend = UART_req | M1_req;
    // rr_q only matters when both low-priority requesters are pending.
    assign pick_m1  = M1_req & (~UART_req | rr_q);
    assign forced   = (starve_q == CW'(MAX_WAIT)) & low_pend;

    always_comb begin
        VGA_gnt  = 1'b0;
        UART_gnt = 1'b0;
        M1_gnt   = 1'b0;
        if (Resetn) begin
            if (forced || (!VGA_req && low_pend)) begin
                M1_gnt   = pick_m1;
                UART_gnt = ~pick_m1;
            end else if (VGA_req) begin
                VGA_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (UART_req && M1_req && (UART_gnt || M1_gnt)) begin
            rr_d = UART_gnt;
        end
        starve_d = starve_q;
        if (UART_gnt || M1_gnt || !low_pend) begin
            starve_d = '0;
        end else if (starve_q != CW'(MAX_WAIT)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_comb begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        if (VGA_gnt) begin
            SRAM_address = VGA_address;
        end else if (UART_gnt) begin
            SRAM_address    = UART_address;
            SRAM_write_data = UART_write_data;
            SRAM_we_n       = 1'b0;
        end else if (M1_gnt) begin
            SRAM_address    = M1_address;
            SRAM_write_data = M1_write_data;
            SRAM_we_n       = M1_we_n;
        end
    end

    assign tag_d = {VGA_gnt, M1_gnt & M1_we_n};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            starve_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rr_q     <= rr_d;
        end
    end

    // Tag shift register: stage READ_LATENCY-1 lines up with the SRAM data return.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_first
                always_ff @(posedge Clock or negedge Resetn) begin
                    if (!Resetn) tag_q[gi] <= 2'b00;
                    else         tag_q[gi] <= tag_d;
                end
            end else begin : g_rest
                always_ff @(posedge Clock or negedge Resetn) begin
                    if (!Resetn) tag_q[gi] <= 2'b00;
                    else         tag_q[gi] <= tag_q[gi-1];
                end
            end
        end
    endgenerate

    assign VGA_read_valid = tag_q[READ_LATENCY-1][1];
    assign M1_read_valid  = tag_q[READ_LATENCY-1][0];

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: per-cycle vector tables, a behavioural SRAM with
// two-cycle read latency, and a scoreboard of expected read returns.
module tb_sram_arbiter;

    logic        Clock;
    logic        Resetn;
    logic        VGA_req, UART_req, M1_req, M1_we_n;
    logic [17:0] VGA_address, UART_address, M1_address;
    logic [15:0] UART_write_data, M1_write_data;
    logic        VGA_gnt, UART_gnt, M1_gnt;
    logic        VGA_read_valid, M1_read_valid;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    sram_arbiter #(.READ_LATENCY(2), .MAX_WAIT(8)) dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .VGA_req        (VGA_req),
        .VGA_address    (VGA_address),
        .VGA_gnt        (VGA_gnt),
        .VGA_read_valid (VGA_read_valid),
        .UART_req       (UART_req),
        .UART_address   (UART_address),
        .UART_write_data(UART_write_data),
        .UART_gnt       (UART_gnt),
        .M1_req         (M1_req),
        .M1_we_n        (M1_we_n),
        .M1_address     (M1_address),
        .M1_write_data  (M1_write_data),
        .M1_gnt         (M1_gnt),
        .M1_read_valid  (M1_read_valid),
        .SRAM_address   (SRAM_address),
        .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data)
    );

    initial begin
        Clock = 1'b0;
        forever #10 Clock = ~Clock;
    end

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural SRAM controller: write on the edge, read data two edges later.
    logic [15:0] sram_mem [512];
    logic [15:0] rd_pipe0, rd_pipe1;
    assign SRAM_read_data = rd_pipe1;
    always @(posedge Clock) begin
        if (!SRAM_we_n) sram_mem[SRAM_address[8:0]] = SRAM_write_data;
        rd_pipe0 <= sram_mem[SRAM_address[8:0]];
        rd_pipe1 <= rd_pipe0;
    end

    typedef struct {
        logic        rstn, v, u, m, mwe_n;
        logic [17:0] va, ua, ma;
        logic [15:0] ud, md;
        logic [2:0]  eg;   // expected {VGA_gnt, UART_gnt, M1_gnt}
    } vec_t;

    typedef struct {
        logic        vga;
        logic [15:0] data;
        int          due;
    } sb_t;

    localparam logic [2:0] GV = 3'b100, GU = 3'b010, GM = 3'b001, GN = 3'b000;

    logic [15:0] ref_mem [512];
    sb_t         sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       cur;

    function automatic vec_t mk(logic rstn, logic v, logic u, logic m, logic mwe_n,
                                logic [17:0] va, logic [17:0] ua, logic [17:0] ma,
                                logic [15:0] ud, logic [15:0] md, logic [2:0] eg);
        vec_t r;
        r.rstn = rstn; r.v = v; r.u = u; r.m = m; r.mwe_n = mwe_n;
        r.va = va; r.ua = ua; r.ma = ma; r.ud = ud; r.md = md; r.eg = eg;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, GN);
    endfunction

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s @cyc %0d: got %h expected %h", cur, what, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t r, input string nm);
        logic        exp_vv, exp_mv, ew;
        logic [15:0] exp_d, ed;
        logic [17:0] ea;
        cur             = nm;
        Resetn          = r.rstn;
        VGA_req         = r.v;
        VGA_address     = r.va;
        UART_req        = r.u;
        UART_address    = r.ua;
        UART_write_data = r.ud;
        M1_req          = r.m;
        M1_we_n         = r.mwe_n;
        M1_address      = r.ma;
        M1_write_data   = r.md;
        if (!r.rstn) sb.delete();
        @(negedge Clock);
        while (sb.size() > 0 && sb[0].due < cyc) begin
            chk("lost_read_valid", 32'(sb[0].due), 32'(cyc));
            void'(sb.pop_front());
        end
        exp_vv = 1'b0; exp_mv = 1'b0; exp_d = 16'h0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_vv = sb[0].vga;
            exp_mv = ~sb[0].vga;
            exp_d  = sb[0].data;
            void'(sb.pop_front());
        end
        case (r.eg)
            GV:      begin ea = r.va; ed = 16'h0; ew = 1'b1;    end
            GU:      begin ea = r.ua; ed = r.ud;  ew = 1'b0;    end
            GM:      begin ea = r.ma; ed = r.md;  ew = r.mwe_n; end
            default: begin ea = 18'h0; ed = 16'h0; ew = 1'b1;   end
        endcase
        chk("gnt", 32'({VGA_gnt, UART_gnt, M1_gnt}), 32'(r.eg));
        chk("sram_addr", 32'(SRAM_address), 32'(ea));
        chk("sram_wdata", 32'(SRAM_write_data), 32'(ed));
        chk("sram_we_n", 32'(SRAM_we_n), 32'(ew));
        chk("vga_read_valid", 32'(VGA_read_valid), 32'(exp_vv));
        chk("m1_read_valid", 32'(M1_read_valid), 32'(exp_mv));
        if (exp_vv || exp_mv) chk("read_data", 32'(SRAM_read_data), 32'(exp_d));
        if (r.eg == GV) sb.push_back('{vga: 1'b1, data: ref_mem[r.va[8:0]], due: cyc + 2});
        if (r.eg == GM && r.mwe_n) sb.push_back('{vga: 1'b0, data: ref_mem[r.ma[8:0]], due: cyc + 2});
        if (r.eg == GU) ref_mem[r.ua[8:0]] = r.ud;
        if (r.eg == GM && !r.mwe_n) ref_mem[r.ma[8:0]] = r.md;
        $display("[TB] %s cyc %0d gnt=%b we_n=%b addr=%h vv=%b mv=%b rd=%h",
                 nm, cyc, {VGA_gnt, UART_gnt, M1_gnt}, SRAM_we_n, SRAM_address,
                 VGA_read_valid, M1_read_valid, SRAM_read_data);
        @(posedge Clock);
        #1;
    endtask

    vec_t tbl [$];

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        sram_mem[9'h100] = 16'hABCD;
        ref_mem[9'h100]  = 16'hABCD;
        Resetn = 1'b0;
        VGA_req = 0; UART_req = 0; M1_req = 0; M1_we_n = 1;
        VGA_address = 0; UART_address = 0; M1_address = 0;
        UART_write_data = 0; M1_write_data = 0;
        @(posedge Clock);
        #1;

        // Reset with all requests high, then release: VGA wins the first cycle.
        tbl.delete();
        tbl.push_back(mk(0, 1, 1, 1, 1, 'h100, 'h60, 'h61, 'h0BAD, 0, GN));
        tbl.push_back(mk(0, 1, 1, 1, 1, 'h100, 'h60, 'h61, 'h0BAD, 0, GN));
        tbl.push_back(mk(1, 1, 1, 1, 1, 'h100, 'h60, 'h61, 'h0BAD, 0, GV));
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        foreach (tbl[i]) apply(tbl[i], "reset");

        // Main table: VGA read, round-robin writes, read-back, priority, M1 write/read.
        tbl.delete();
        tbl.push_back(mk(1, 1, 0, 0, 1, 'h100, 0, 0, 0, 0, GV));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h10, 'h20, 'h1111, 'h2222, GU));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h11, 'h20, 'h3333, 'h2222, GM));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h11, 'h21, 'h3333, 'h4444, GU));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h12, 'h21, 'h5555, 'h4444, GM));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h10, 0, 0, GM));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h11, 0, 0, GM));
        tbl.push_back(mk(1, 1, 0, 0, 1, 'h20, 0, 0, 0, 0, GV));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h21, 0, 0, GM));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h12, 0, 0, GM));
        tbl.push_back(mk(1, 1, 1, 0, 1, 'h100, 'h30, 0, 'h6666, 0, GV));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 'h30, 0, 'h6666, 0, GU));
        tbl.push_back(mk(1, 1, 0, 1, 1, 'h10, 0, 'h20, 0, 0, GV));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h20, 0, 0, GM));
        tbl.push_back(mk(1, 1, 1, 1, 0, 'h0, 'h31, 'h32, 'h7777, 'h8888, GV));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h31, 'h32, 'h7777, 'h8888, GU));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 'h33, 'h32, 'h9999, 'h8888, GM));
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 'h33, 0, 'h9999, 0, GU));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 'h5, 0, 'h1234, GM));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h5, 0, 0, GM));
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        foreach (tbl[i]) apply(tbl[i], "main");

        // Starvation: VGA holds off UART for MAX_WAIT cycles, then UART is forced in.
        tbl.delete();
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 1, 1, 0, 1, 'h100, 'h50, 0, 'hAAAA, 0, GV));
        tbl.push_back(mk(1, 1, 1, 0, 1, 'h100, 'h50, 0, 'hAAAA, 0, GU));
        tbl.push_back(mk(1, 1, 0, 0, 1, 'h50, 0, 0, 0, 0, GV));
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        foreach (tbl[i]) apply(tbl[i], "starve");

        // Mid-flight reset: the M1 read in flight must never report valid.
        tbl.delete();
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 'h5, 0, 0, GM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, GN));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());
        foreach (tbl[i]) apply(tbl[i], "midreset");

        cur = "end";
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port between three requesters: the VGA pixel fetcher, the UART image loader and the Milestone-1 colour-space/upsampling datapath. It sits between those blocks and the SRAM controller. It grants at most one access per cycle: fixed top priority for VGA, round-robin between UART and M1, and a starvation guard. It returns read data tagged with a per-requester valid that is aligned to the SRAM read latency.

## Interface
Parameters:
- READ_LATENCY, 2, cycles from a granted read to its data appearing on SRAM_read_data
- MAX_WAIT, 8, consecutive denied cycles after which a pending UART/M1 request pre-empts VGA

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous active-low reset
- VGA_req  in  1  VGA read request
- VGA_address  in  18  VGA read address
- VGA_gnt  out  1  VGA request granted this cycle
- VGA_read_valid  out  1  SRAM_read_data belongs to VGA this cycle
- UART_req  in  1  UART write request
- UART_address  in  18  UART write address
- UART_write_data  in  16  UART write data
- UART_gnt  out  1  UART request granted this cycle
- M1_req  in  1  M1 request
- M1_we_n  in  1  M1 write enable, active-low (1 = read)
- M1_address  in  18  M1 address
- M1_write_data  in  16  M1 write data
- M1_gnt  out  1  M1 request granted this cycle
- M1_read_valid  out  1  SRAM_read_data belongs to M1 this cycle
- SRAM_address  out  18  address to SRAM controller
- SRAM_write_data  out  16  write data to SRAM controller
- SRAM_we_n  out  1  write enable to SRAM controller, active-low
- SRAM_read_data  in  16  read data from SRAM controller; requesters consume it directly

## Operation
- Grant is combinational from the req inputs plus registered arbiter state. At most one gnt is high per cycle. A requester keeps req and its operands stable until it sees gnt.
- Priority, evaluated in order:
  - forced grant: if starve_cnt == MAX_WAIT and a UART or M1 request is pending, grant the one rr_ptr selects (or the only one pending), even if VGA_req is high;
  - otherwise VGA_req wins;
  - otherwise, if only one of UART/M1 requests, it wins;
  - otherwise rr_ptr picks the winner.
- rr_ptr is 1 bit, 0 = UART, 1 = M1. It toggles to the loser only when UART and M1 both request in the same cycle and one of them is granted. It is unchanged otherwise.
- starve_cnt: log2(MAX_WAIT)+1 bits.
  - Increments (saturating at MAX_WAIT) each cycle in which UART_req or M1_req is high and neither is granted.
  - Clears to 0 on any UART or M1 grant, and when both of those reqs are low.
- SRAM mux:
  - The granted requester's address and data drive SRAM_address and SRAM_write_data.
  - SRAM_we_n = 0 for a UART grant or an M1 grant with M1_we_n = 0; otherwise SRAM_we_n = 1.
  - With no grant: SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1.
- Read return: a READ_LATENCY-deep shift register of 2-bit tags {vga_rd, m1_rd} is loaded every cycle with the granted read, or 00 if there is none. Its output drives VGA_read_valid and M1_read_valid. Writes push 00.

## Timing
- Reset values: all gnt outputs 0, both read_valid 0, SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0, rr_ptr 0, starve_cnt 0, tag pipeline 00.
- While Resetn is low, all grants are forced to 0 regardless of req.
- Reset mid-operation flushes in-flight tags. No read_valid fires for reads granted before reset.
- Grant latency is 0 cycles when the requester wins. The worst case for UART/M1 under continuous VGA traffic is MAX_WAIT+1 cycles.
- A read granted in cycle N gives its read_valid in cycle N+READ_LATENCY, with the data on SRAM_read_data in the same cycle.
- Back-to-back grants to any mix of requesters are legal every cycle. The throughput is one access per cycle.

## Test plan
- Reset: assert Resetn=0 while all three reqs are high -> all gnt 0, SRAM_we_n 1. After release, VGA_gnt=1 in the first cycle.
- VGA read: VGA_req for 1 cycle at address 18'h0100 with SRAM contents 16'hABCD -> VGA_gnt that cycle, VGA_read_valid exactly 2 cycles later with SRAM_read_data = 16'hABCD, and M1_read_valid stays 0.
- Round-robin: UART and M1 request continuously, VGA idle -> grants alternate UART, M1, UART, M1 starting with UART, and no write is lost.
- Starvation: VGA_req held high with UART_req high from cycle 0 -> VGA_gnt for cycles 0-7, UART_gnt at cycle 8, VGA_gnt resumes at cycle 9.
- Mixed M1 traffic: M1 write of 16'h1234 to address 5, then M1 read of address 5 on the next cycle -> SRAM_we_n is 0 then 1, and M1_read_valid is high 2 cycles after the read grant with data 16'h1234.
- Mid-flight reset: grant an M1 read, then pulse Resetn low for one cycle -> no M1_read_valid appears afterwards.
